// File: rtl/tcam_pkg.sv
// Shared TCAM types and default geometry for the match core and its priority encoder.
package tcam_pkg;

    localparam int unsigned KEY_W   = 128;
    localparam int unsigned ENTRIES = 16;
    localparam int unsigned IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    typedef struct packed {
        logic             hit;
        logic [IDX_W-1:0] idx;
    } tcam_result_t;

endpackage

// File: rtl/tcam_prio_enc.sv
// Combinational priority encoder: lowest set bit of the match vector wins; empty vector -> idx 0.
module tcam_prio_enc
    import tcam_pkg::*;
#(
    parameter int unsigned Width = ENTRIES,
    parameter int unsigned IdxW  = IDX_W
) (
    input  logic [Width-1:0] vec_i,
    output logic             hit_o,
    output logic [IdxW-1:0]  idx_o
);

    always_comb begin
        hit_o = |vec_i;
        idx_o = '0;
        // Scan high to low so the lowest matching index is the last one written.
        for (int i = int'(Width) - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IdxW'(i);
            end
        end
    end

endmodule

// File: rtl/tcam_match_core.sv
// Ternary match array with a 2-stage valid/ready lookup pipeline (compare, priority-encode).
// Optional hit/miss counters are built when TCAM_STATS_EN is defined.
module tcam_match_core
    import tcam_pkg::*;
#(
    parameter int unsigned KeyW    = KEY_W,
    parameter int unsigned Entries = ENTRIES
) (
    input  logic              clk_i,
    input  logic              resetn_i,
    input  logic [IDX_W-1:0]  tcam_wr_addr_i,
    input  logic              tcam_wr_is_mask_i,
    input  logic [KeyW-1:0]   tcam_wr_data_i,
    input  logic              tcam_wr_en_i,
    input  logic              lk_valid_i,
    output logic              lk_ready_o,
    input  logic [KeyW-1:0]   lk_key_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic              res_hit_o,
    output logic [IDX_W-1:0]  res_idx_o
`ifdef TCAM_STATS_EN
    ,
    input  logic              stat_clr_i,
    output logic [31:0]       stat_hit_cnt_o,
    output logic [31:0]       stat_miss_cnt_o
`endif
);

    logic [KeyW-1:0]    value_q [Entries];
    logic [KeyW-1:0]    mask_q  [Entries];
    logic [Entries-1:0] vld_q;

    logic [Entries-1:0] match;
    logic               adv;

    logic               s1_valid_q;
    logic [Entries-1:0] s1_match_q;

    logic               res_valid_q;
    tcam_result_t       res_q;
    tcam_result_t       res_d;

    // Value/mask words carry no reset; vld gates them until written.
    always_ff @(posedge clk_i) begin
        if (tcam_wr_en_i) begin
            if (tcam_wr_is_mask_i) begin
                mask_q[tcam_wr_addr_i] <= tcam_wr_data_i;
            end else begin
                value_q[tcam_wr_addr_i] <= tcam_wr_data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            vld_q <= '0;
        end else if (tcam_wr_en_i && !tcam_wr_is_mask_i) begin
            vld_q[tcam_wr_addr_i] <= 1'b1;
        end
    end

    always_comb begin
        match = '0;
        for (int i = 0; i < int'(Entries); i++) begin
            match[i] = vld_q[i] && (((lk_key_i ^ value_q[i]) & mask_q[i]) == '0);
        end
    end

    assign adv        = !res_valid_q || res_ready_i;
    assign lk_ready_o = adv;

    tcam_prio_enc #(
        .Width (Entries),
        .IdxW  (IDX_W)
    ) u_prio_enc (
        .vec_i (s1_match_q),
        .hit_o (res_d.hit),
        .idx_o (res_d.idx)
    );

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            s1_valid_q  <= 1'b0;
            s1_match_q  <= '0;
            res_valid_q <= 1'b0;
            res_q       <= '0;
        end else if (adv) begin
            s1_valid_q  <= lk_valid_i;
            s1_match_q  <= match;
            res_valid_q <= s1_valid_q;
            res_q       <= res_d;
        end
    end

    assign res_valid_o = res_valid_q;
    assign res_hit_o   = res_q.hit;
    assign res_idx_o   = res_q.idx;

`ifdef TCAM_STATS_EN
    localparam logic [31:0] CntMax = 32'hFFFF_FFFF;

    logic        res_hs;
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    assign res_hs = res_valid_q && res_ready_i;

    always_ff @(posedge clk_i) begin
        if (!resetn_i || stat_clr_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (res_hs) begin
            if (res_q.hit) begin
                if (hit_cnt_q != CntMax) begin
                    hit_cnt_q <= hit_cnt_q + 32'd1;
                end
            end else if (miss_cnt_q != CntMax) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign stat_hit_cnt_o  = hit_cnt_q;
    assign stat_miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_tcam_match_core.sv
// Directed bench for tcam_match_core; exercises the stats counters when TCAM_STATS_EN is defined.
module tb_tcam_match_core;
    import tcam_pkg::*;

    logic              clk;
    logic              resetn;
    logic [IDX_W-1:0]  wr_addr;
    logic              wr_is_mask;
    logic [KEY_W-1:0]  wr_data;
    logic              wr_en;
    logic              lk_valid;
    logic              lk_ready;
    logic [KEY_W-1:0]  lk_key;
    logic              res_valid;
    logic              res_ready;
    logic              res_hit;
    logic [IDX_W-1:0]  res_idx;
`ifdef TCAM_STATS_EN
    logic              stat_clr;
    logic [31:0]       stat_hit_cnt;
    logic [31:0]       stat_miss_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    tcam_match_core u_dut (
        .clk_i             (clk),
        .resetn_i          (resetn),
        .tcam_wr_addr_i    (wr_addr),
        .tcam_wr_is_mask_i (wr_is_mask),
        .tcam_wr_data_i    (wr_data),
        .tcam_wr_en_i      (wr_en),
        .lk_valid_i        (lk_valid),
        .lk_ready_o        (lk_ready),
        .lk_key_i          (lk_key),
        .res_valid_o       (res_valid),
        .res_ready_i       (res_ready),
        .res_hit_o         (res_hit),
        .res_idx_o         (res_idx)
`ifdef TCAM_STATS_EN
        ,
        .stat_clr_i        (stat_clr),
        .stat_hit_cnt_o    (stat_hit_cnt),
        .stat_miss_cnt_o   (stat_miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic write_word(input int addr, input logic is_mask, input logic [KEY_W-1:0] data);
        wr_addr    = IDX_W'(addr);
        wr_is_mask = is_mask;
        wr_data    = data;
        wr_en      = 1'b1;
        @(posedge clk);
        #1;
        wr_en      = 1'b0;
    endtask

    // Single lookup into an idle pipeline with res_ready held high; checks N+2 latency.
    task automatic lookup(input string tag, input logic [KEY_W-1:0] key,
                          input logic exp_hit, input int exp_idx);
        lk_valid = 1'b1;
        lk_key   = key;
        #1;
        check({tag, "_lk_ready"}, 32'(lk_ready), 32'd1);
        @(posedge clk);
        #1;
        lk_valid = 1'b0;
        check({tag, "_valid_n1"}, 32'(res_valid), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_valid_n2"}, 32'(res_valid), 32'd1);
        check({tag, "_hit"}, 32'(res_hit), 32'(exp_hit));
        check({tag, "_idx"}, 32'(res_idx), 32'(exp_idx));
    endtask

    logic [KEY_W-1:0] bb_key [8];
    logic             bb_hit [8];
    int               bb_idx [8];

    initial begin
        resetn     = 1'b0;
        wr_addr    = '0;
        wr_is_mask = 1'b0;
        wr_data    = '0;
        wr_en      = 1'b0;
        lk_valid   = 1'b0;
        lk_key     = '0;
        res_ready  = 1'b1;
`ifdef TCAM_STATS_EN
        stat_clr   = 1'b0;
`endif

        // Reset state and empty-table lookup
        do_reset();
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_hit", 32'(res_hit), 32'd0);
        check("rst_res_idx", 32'(res_idx), 32'd0);
        check("rst_lk_ready", 32'(lk_ready), 32'd1);
        lookup("empty", '0, 1'b0, 0);

        // Exact entry 3
        write_word(3, 1'b1, '1);
        write_word(3, 1'b0, 128'hDEAD_BEEF);
        lookup("e3_hit", 128'hDEAD_BEEF, 1'b1, 3);
        lookup("e3_miss", 128'hDEAD_BEE0, 1'b0, 0);

        // Wildcard entry 5 behind exact entry 2
        write_word(5, 1'b1, '0);
        write_word(5, 1'b0, 128'h5555);
        write_word(2, 1'b1, '1);
        write_word(2, 1'b0, 128'h1234);
        lookup("prio_e2", 128'h1234, 1'b1, 2);
        lookup("wild_e5", 128'h9999, 1'b1, 5);
        lookup("prio_e3", 128'hDEAD_BEEF, 1'b1, 3);

        // Back-to-back keys with res_ready low in cycles 3..6
        do_reset();
        for (int i = 0; i < 8; i++) begin
            write_word(i, 1'b1, '1);
            write_word(i, 1'b0, KEY_W'(32'h100 + i));
        end
        bb_key[0] = 128'h107; bb_hit[0] = 1'b1; bb_idx[0] = 7;
        bb_key[1] = 128'h100; bb_hit[1] = 1'b1; bb_idx[1] = 0;
        bb_key[2] = 128'h1FF; bb_hit[2] = 1'b0; bb_idx[2] = 0;
        bb_key[3] = 128'h103; bb_hit[3] = 1'b1; bb_idx[3] = 3;
        bb_key[4] = 128'h106; bb_hit[4] = 1'b1; bb_idx[4] = 6;
        bb_key[5] = 128'h101; bb_hit[5] = 1'b1; bb_idx[5] = 1;
        bb_key[6] = 128'h000; bb_hit[6] = 1'b0; bb_idx[6] = 0;
        bb_key[7] = 128'h104; bb_hit[7] = 1'b1; bb_idx[7] = 4;
        begin
            int sent = 0;
            int got  = 0;
            for (int c = 0; c < 30; c++) begin
                res_ready = !(c >= 3 && c <= 6);
                lk_valid  = (sent < 8);
                lk_key    = (sent < 8) ? bb_key[sent] : '0;
                #1;
                if (res_valid && !res_ready) begin
                    check("bb_stall_lk_ready", 32'(lk_ready), 32'd0);
                end
                if (res_valid && res_ready) begin
                    if (got < 8) begin
                        check("bb_hit", 32'(res_hit), 32'(bb_hit[got]));
                        check("bb_idx", 32'(res_idx), 32'(bb_idx[got]));
                    end
                    got++;
                end
                if (lk_valid && lk_ready) begin
                    sent++;
                end
                @(posedge clk);
                #1;
            end
            check("bb_result_count", 32'(got), 32'd8);
            lk_valid  = 1'b0;
            res_ready = 1'b1;
        end

        // Write and lookup in the same cycle: first key misses, next one hits
        do_reset();
        write_word(0, 1'b1, '1);
        wr_addr    = '0;
        wr_is_mask = 1'b0;
        wr_data    = 128'hAA;
        wr_en      = 1'b1;
        lk_valid   = 1'b1;
        lk_key     = 128'hAA;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        @(posedge clk);
        #1;
        lk_valid = 1'b0;
        check("wr_same_valid", 32'(res_valid), 32'd1);
        check("wr_same_hit", 32'(res_hit), 32'd0);
        @(posedge clk);
        #1;
        check("wr_next_valid", 32'(res_valid), 32'd1);
        check("wr_next_hit", 32'(res_hit), 32'd1);
        check("wr_next_idx", 32'(res_idx), 32'd0);
        @(posedge clk);
        #1;

        // Reset while a lookup is in flight
        lk_valid = 1'b1;
        lk_key   = 128'hAA;
        @(posedge clk);
        #1;
        lk_valid = 1'b0;
        resetn   = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_valid_a", 32'(res_valid), 32'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_valid_b", 32'(res_valid), 32'd0);
        lookup("midrst_vld_clr", 128'hAA, 1'b0, 0);

`ifdef TCAM_STATS_EN
        do_reset();
        check("stat_rst_hit", stat_hit_cnt, 32'd0);
        check("stat_rst_miss", stat_miss_cnt, 32'd0);
        write_word(1, 1'b1, '1);
        write_word(1, 1'b0, 128'h77);
        lookup("st_h0", 128'h77, 1'b1, 1);
        lookup("st_m0", 128'h11, 1'b0, 0);
        lookup("st_h1", 128'h77, 1'b1, 1);
        lookup("st_m1", 128'h11, 1'b0, 0);
        lookup("st_h2", 128'h77, 1'b1, 1);
        @(posedge clk);
        #1;
        check("stat_hit_cnt", stat_hit_cnt, 32'd3);
        check("stat_miss_cnt", stat_miss_cnt, 32'd2);
        lookup("st_clr", 128'h77, 1'b1, 1);
        stat_clr = 1'b1;
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
        check("stat_clr_hit", stat_hit_cnt, 32'd0);
        check("stat_clr_miss", stat_miss_cnt, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
